// File: rtl/carry_resolver_packer.sv
`default_nettype none
// ============================================================================
// Module   : carry_resolver_packer
// Purpose  : Collects the encoder's pre-bitstream words (up to six per cycle,
//            three lanes with two words each), buffers them in a word FIFO and
//            resolves carries one word per cycle. It keeps one pending byte
//            plus a count of deferred 0xFF bytes. Final bytes leave through a
//            single valid/ready output register.
// Ports    : general_clk, reset    - clock, synchronous active-high reset
//            in_valid, in_flag_1..3, in_word_1_1..in_word_3_2
//                                  - per-lane word counts and words
//            flush / flush_done    - end-of-frame request / completion pulse
//            out_byte, out_valid, out_ready - resolved byte stream
//            fifo_level            - words currently buffered
//            err_status            - sticky [0] overflow, [1] carry error,
//                                    [2] reserved flag or run saturation
// Revision : 1.0 - initial release
// ============================================================================
module carry_resolver_packer #(
    parameter int WORD_WIDTH = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int RUN_WIDTH  = 16
) (
    input  logic                          general_clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [1:0]                    in_flag_1,
    input  logic [1:0]                    in_flag_2,
    input  logic [1:0]                    in_flag_3,
    input  logic [WORD_WIDTH-1:0]         in_word_1_1,
    input  logic [WORD_WIDTH-1:0]         in_word_1_2,
    input  logic [WORD_WIDTH-1:0]         in_word_2_1,
    input  logic [WORD_WIDTH-1:0]         in_word_2_2,
    input  logic [WORD_WIDTH-1:0]         in_word_3_1,
    input  logic [WORD_WIDTH-1:0]         in_word_3_2,
    input  logic                          flush,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          flush_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [2:0]                    err_status
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam logic [RUN_WIDTH-1:0] RUN_MAX = {RUN_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_RESOLVE    = 3'd0,
        S_RUN        = 3'd1,
        S_FLUSH_PEND = 3'd2,
        S_FLUSH_RUN  = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    // Only the carry bit and the byte are meaningful; the upper bits are dropped.
    logic unused_word_hi;
    assign unused_word_hi = ^{in_word_1_1[WORD_WIDTH-1:9], in_word_1_2[WORD_WIDTH-1:9],
                              in_word_2_1[WORD_WIDTH-1:9], in_word_2_2[WORD_WIDTH-1:9],
                              in_word_3_1[WORD_WIDTH-1:9], in_word_3_2[WORD_WIDTH-1:9]};

    logic [1:0] lane_flag [3];
    logic [8:0] lane_w1   [3];
    logic [8:0] lane_w2   [3];

    assign lane_flag[0] = in_flag_1;
    assign lane_flag[1] = in_flag_2;
    assign lane_flag[2] = in_flag_3;
    assign lane_w1[0]   = in_word_1_1[8:0];
    assign lane_w2[0]   = in_word_1_2[8:0];
    assign lane_w1[1]   = in_word_2_1[8:0];
    assign lane_w2[1]   = in_word_2_2[8:0];
    assign lane_w1[2]   = in_word_3_1[8:0];
    assign lane_w2[2]   = in_word_3_2[8:0];

    // ------------------------------------------------------------------
    // Lane compaction: valid words packed in lane order into slot[0..5]
    // ------------------------------------------------------------------
    logic [8:0] slot [8];
    logic [2:0] push_cnt;
    logic       flag_reserved;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            slot[i] = '0;
        end
        push_cnt      = '0;
        flag_reserved = 1'b0;
        for (int l = 0; l < 3; l++) begin
            case (lane_flag[l])
                2'd1: begin
                    slot[push_cnt] = lane_w1[l];
                    push_cnt       = push_cnt + 3'd1;
                end
                2'd2: begin
                    slot[push_cnt]        = lane_w1[l];
                    slot[push_cnt + 3'd1] = lane_w2[l];
                    push_cnt              = push_cnt + 3'd2;
                end
                2'd3:    flag_reserved = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [8:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [LVL_W-1:0]  free_cnt;
    logic              push_fits;
    logic              push_ok;
    logic              overflow;
    logic              slot_free;
    logic              pop;
    state_t            state;

    assign free_cnt  = LVL_W'(FIFO_DEPTH) - fifo_level;
    assign push_fits = LVL_W'(push_cnt) <= free_cnt;
    // The whole cycle is either written or dropped; never a partial write.
    assign push_ok   = in_valid && (push_cnt != 3'd0) && push_fits;
    assign overflow  = in_valid && (push_cnt != 3'd0) && !push_fits;
    assign slot_free = !out_valid || out_ready;
    assign pop       = (state == S_RESOLVE) && (fifo_level != '0) && slot_free;

    always_ff @(posedge general_clk) begin
        if (push_ok && !reset) begin
            for (int i = 0; i < 6; i++) begin
                if (3'(i) < push_cnt) begin
                    mem[wr_ptr + ADDR_W'(i)] <= slot[i];
                end
            end
        end
    end

    always_ff @(posedge general_clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(push_cnt);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            fifo_level <= fifo_level + (push_ok ? LVL_W'(push_cnt) : LVL_W'(0)) - LVL_W'(pop);
        end
    end

    logic       head_c;
    logic [7:0] head_b;
    assign head_c = mem[rd_ptr][8];
    assign head_b = mem[rd_ptr][7:0];

    // ------------------------------------------------------------------
    // Carry resolution and output register
    // ------------------------------------------------------------------
    logic [7:0]           pend;
    logic                 pend_v;
    logic [RUN_WIDTH-1:0] run;
    logic [RUN_WIDTH-1:0] run_left;
    logic [7:0]           fill;
    logic                 flush_req;

    always_ff @(posedge general_clk) begin
        if (reset) begin
            state      <= S_RESOLVE;
            pend       <= '0;
            pend_v     <= 1'b0;
            run        <= '0;
            run_left   <= '0;
            fill       <= '0;
            flush_req  <= 1'b0;
            out_valid  <= 1'b0;
            out_byte   <= '0;
            flush_done <= 1'b0;
            err_status <= '0;
        end else begin
            flush_done <= 1'b0;
            // An accepted byte frees the slot; an emit below re-fills it.
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (flush && !flush_req) begin
                flush_req <= 1'b1;
            end
            if (overflow) begin
                err_status[0] <= 1'b1;
            end
            if (in_valid && flag_reserved) begin
                err_status[2] <= 1'b1;
            end

            case (state)
                S_RESOLVE: begin
                    if (pop) begin
                        if (!pend_v) begin
                            pend   <= head_b;
                            pend_v <= 1'b1;
                            // Carry into a byte that does not exist.
                            if (head_c) begin
                                err_status[1] <= 1'b1;
                            end
                        end else if (!head_c && head_b == 8'hFF) begin
                            // 0xFF may still absorb a later carry: defer it.
                            if (run == RUN_MAX) begin
                                err_status[2] <= 1'b1;
                            end else begin
                                run <= run + RUN_WIDTH'(1);
                            end
                        end else begin
                            out_valid <= 1'b1;
                            out_byte  <= head_c ? pend + 8'd1 : pend;
                            if (head_c && pend == 8'hFF) begin
                                err_status[1] <= 1'b1;
                            end
                            pend <= head_b;
                            if (run != '0) begin
                                // A carry turns the deferred 0xFF run into zeros.
                                fill     <= head_c ? 8'h00 : 8'hFF;
                                run_left <= run;
                                run      <= '0;
                                state    <= S_RUN;
                            end
                        end
                    end else if (fifo_level == '0 && flush_req && slot_free) begin
                        state <= pend_v ? S_FLUSH_PEND : S_DONE;
                    end
                end

                S_RUN, S_FLUSH_RUN: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_byte  <= fill;
                        run_left  <= run_left - RUN_WIDTH'(1);
                        if (run_left == RUN_WIDTH'(1)) begin
                            state <= (state == S_RUN) ? S_RESOLVE : S_DONE;
                        end
                    end
                end

                S_FLUSH_PEND: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_byte  <= pend;
                        pend_v    <= 1'b0;
                        if (run != '0) begin
                            fill     <= 8'hFF;
                            run_left <= run;
                            run      <= '0;
                            state    <= S_FLUSH_RUN;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // Completion is signalled only once the last byte has left.
                    if (!out_valid) begin
                        flush_done <= 1'b1;
                        flush_req  <= 1'b0;
                        state      <= S_RESOLVE;
                    end
                end

                default: state <= S_RESOLVE;
            endcase
        end
    end

endmodule
`default_nettype wire
